// File: rtl/set_concurrency_lock_if.sv
// Handshake bundle between the CPU-side and snoopy-side controllers and the
// per-set concurrency lock. The master modport is the controller side (drives
// requests and releases); the slave modport is the lock itself.
interface set_concurrency_lock_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int STREAK_WIDTH  = 2
);
  logic                     cpuRequest;
  logic [ADDRESS_WIDTH-1:0] cpuAddress;
  logic                     cpuRelease;
  logic                     cpuGrant;
  logic                     cpuBlocked;
  logic                     snoopyRequest;
  logic [ADDRESS_WIDTH-1:0] snoopyAddress;
  logic                     snoopyRelease;
  logic                     snoopyGrant;
  logic [STREAK_WIDTH-1:0]  snoopStreak;

  modport master (
    output cpuRequest, cpuAddress, cpuRelease,
    output snoopyRequest, snoopyAddress, snoopyRelease,
    input  cpuGrant, cpuBlocked, snoopyGrant, snoopStreak
  );

  modport slave (
    input  cpuRequest, cpuAddress, cpuRelease,
    input  snoopyRequest, snoopyAddress, snoopyRelease,
    output cpuGrant, cpuBlocked, snoopyGrant, snoopStreak
  );
endinterface

// File: rtl/set_concurrency_lock.sv
// Per-set lock between the CPU-side and snoopy-side cache controllers.
// Each side locks only the set it addresses, so different sets proceed in
// parallel. Same-set contests go to the snoopy side unless it has already won
// MAX_SNOOP_STREAK contests in a row, in which case the CPU side wins once.
module set_concurrency_lock #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int OFFSET_WIDTH     = 4,
  parameter int INDEX_WIDTH      = 6,
  parameter int MAX_SNOOP_STREAK = 3,
  parameter int STREAK_WIDTH     = $clog2(MAX_SNOOP_STREAK + 1)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  set_concurrency_lock_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } lock_state_e;

  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX  = STREAK_WIDTH'(MAX_SNOOP_STREAK);
  localparam logic [STREAK_WIDTH-1:0] STREAK_ONE  = STREAK_WIDTH'(1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_ZERO = STREAK_WIDTH'(0);

  lock_state_e             cpu_state_q, cpu_state_d;
  lock_state_e             snp_state_q, snp_state_d;
  logic [INDEX_WIDTH-1:0]  cpu_index_q, cpu_index_d;
  logic [INDEX_WIDTH-1:0]  snp_index_q, snp_index_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d;

  logic [INDEX_WIDTH-1:0]  cpu_req_index_s;
  logic [INDEX_WIDTH-1:0]  snp_req_index_s;
  logic                    cpu_held_s;
  logic                    snp_held_s;
  logic                    cpu_conflict_s;
  logic                    snp_conflict_s;
  logic                    contest_s;
  logic                    snoop_priority_s;
  logic                    cpu_take_s;
  logic                    snp_take_s;
  logic                    contested_snoop_win_s;
  logic                    unused_addr_bits_s;

  // Only the set-index field takes part in the lock; tag and offset bits are
  // deliberately ignored.
  assign cpu_req_index_s = bus.cpuAddress[OFFSET_WIDTH +: INDEX_WIDTH];
  assign snp_req_index_s = bus.snoopyAddress[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_addr_bits_s = ^{bus.cpuAddress, bus.snoopyAddress};

  assign cpu_held_s = (cpu_state_q == HELD);
  assign snp_held_s = (snp_state_q == HELD);

  // A side is blocked by the other side already holding the same set, judged
  // from registered state only, so a handover always costs one idle cycle.
  assign cpu_conflict_s = snp_held_s && (snp_index_q == cpu_req_index_s);
  assign snp_conflict_s = cpu_held_s && (cpu_index_q == snp_req_index_s);

  // Arbitration is only needed when both are idle and ask for the same set.
  assign contest_s = !cpu_held_s && !snp_held_s && bus.cpuRequest &&
                     bus.snoopyRequest && (cpu_req_index_s == snp_req_index_s);
  assign snoop_priority_s = (streak_q < STREAK_MAX);

  assign cpu_take_s = !cpu_held_s && bus.cpuRequest && !cpu_conflict_s &&
                      !(contest_s && snoop_priority_s);
  assign snp_take_s = !snp_held_s && bus.snoopyRequest && !snp_conflict_s &&
                      !(contest_s && !snoop_priority_s);

  // A snoopy grant is "contested" when the CPU was asking for the same set
  // and lost; with registered-state conflict checks that is exactly an
  // arbitration win by the snoopy side.
  assign contested_snoop_win_s = snp_take_s && contest_s;

  // Next-state logic for both side FSMs, their latched indices and the streak.
  always_comb begin
    cpu_state_d = cpu_state_q;
    snp_state_d = snp_state_q;
    cpu_index_d = cpu_index_q;
    snp_index_d = snp_index_q;
    streak_d    = streak_q;

    case (cpu_state_q)
      IDLE: begin
        if (cpu_take_s) begin
          cpu_state_d = HELD;
          cpu_index_d = cpu_req_index_s;
        end else begin
          cpu_state_d = IDLE;
        end
      end
      HELD: begin
        if (bus.cpuRelease) begin
          cpu_state_d = IDLE;
        end else begin
          cpu_state_d = HELD;
        end
      end
      default: cpu_state_d = IDLE;
    endcase

    case (snp_state_q)
      IDLE: begin
        if (snp_take_s) begin
          snp_state_d = HELD;
          snp_index_d = snp_req_index_s;
        end else begin
          snp_state_d = IDLE;
        end
      end
      HELD: begin
        if (bus.snoopyRelease) begin
          snp_state_d = IDLE;
        end else begin
          snp_state_d = HELD;
        end
      end
      default: snp_state_d = IDLE;
    endcase

    // Any CPU grant resets fairness; contested snoopy wins count up and saturate.
    if (cpu_take_s) begin
      streak_d = STREAK_ZERO;
    end else if (contested_snoop_win_s && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + STREAK_ONE;
    end else begin
      streak_d = streak_q;
    end
  end

  // State registers with synchronous reset that overrides all requests.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cpu_state_q <= IDLE;
      snp_state_q <= IDLE;
      cpu_index_q <= '0;
      snp_index_q <= '0;
      streak_q    <= STREAK_ZERO;
    end else begin
      cpu_state_q <= cpu_state_d;
      snp_state_q <= snp_state_d;
      cpu_index_q <= cpu_index_d;
      snp_index_q <= snp_index_d;
      streak_q    <= streak_d;
    end
  end

  assign bus.cpuGrant    = cpu_held_s;
  assign bus.snoopyGrant = snp_held_s;
  assign bus.snoopStreak = streak_q;
  assign bus.cpuBlocked  = bus.cpuRequest && !cpu_held_s &&
                           (cpu_conflict_s || (contest_s && snoop_priority_s));

endmodule

// File: doc/set_concurrency_lock.md
# set_concurrency_lock

Per-set lock between the CPU-side controller and the snoopy-side controller of a snoopy cache on the invalidate protocol. It generalises the single global concurrency lock: each side locks only the cache set it addresses, so accesses to different sets proceed together. A same-set collision is resolved with snoopy priority. A bounded snoop-streak counter ensures the CPU side cannot starve. The block sits between both controllers and the shared tag/state/data arrays.

## Interface
- ADDRESS_WIDTH, 32, width of both request addresses
- OFFSET_WIDTH, 4, block-offset bits; the set index starts above these
- INDEX_WIDTH, 6, set-index bits; index = address[OFFSET_WIDTH +: INDEX_WIDTH]
- MAX_SNOOP_STREAK, 3, number of consecutive contested snoopy wins after which the CPU wins the next contest; must be ≥ 1
- STREAK_WIDTH, $clog2(MAX_SNOOP_STREAK+1), width of the streak counter
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cpuRequest  in  1  CPU side requests the lock
- cpuAddress  in  ADDRESS_WIDTH  CPU address; stable while cpuRequest=1
- cpuRelease  in  1  CPU side drops its lock; honoured only while cpuGrant=1
- cpuGrant  out  1  CPU side holds the lock on its set
- cpuBlocked  out  1  CPU request pending and denied this cycle
- snoopyRequest  in  1  snoopy side requests the lock
- snoopyAddress  in  ADDRESS_WIDTH  snoopy address; stable while snoopyRequest=1
- snoopyRelease  in  1  snoopy side drops its lock; honoured only while snoopyGrant=1
- snoopyGrant  out  1  snoopy side holds the lock on its set
- snoopStreak  out  STREAK_WIDTH  current streak count

## Operation
- Each side has a two-state FSM, IDLE and HELD. The grant output is the registered HELD flag.
- Each side latches its set index into heldIndex on the IDLE→HELD transition.
- IDLE→HELD happens at the clock edge when all three hold:
  - the side's request=1;
  - the other side is not HELD on the same index, judged from the current-cycle registers;
  - the side wins arbitration.
- HELD→IDLE happens at the edge where release=1. While HELD, request and address are ignored.
- Arbitration applies only when both sides are IDLE, both request, and the indices are equal:
  - snoopy wins if snoopStreak < MAX_SNOOP_STREAK;
  - otherwise CPU wins.
- Both sides IDLE, both requesting, different indices: both granted on the same edge.
- A contested snoopy win is a grant to snoopy on an edge where cpuRequest=1 and the CPU was denied for the same index, either by arbitration or by snoopy already being HELD. Each contested win increments snoopStreak, saturating at MAX_SNOOP_STREAK.
- Any CPU grant clears snoopStreak to 0. An uncontested snoopy grant leaves it unchanged.
- cpuBlocked = cpuRequest & ~cpuGrant & (conflict or lost arbitration). It is combinational from registers and inputs.
- Release while not HELD is ignored. Release and request asserted in the same cycle on an IDLE side: request is evaluated and release is ignored.
- Index compare uses only the INDEX_WIDTH bits. Tags and offsets are irrelevant.

## Timing
- Reset: cpuGrant=0, snoopyGrant=0, snoopStreak=0, both FSMs IDLE, heldIndex=0. cpuBlocked follows its equation.
- Reset asserted mid-operation forces this state at the next edge, whatever the request/release inputs.
- Uncontended latency: request high in cycle t gives grant high in cycle t+1.
- Release high in cycle t gives grant low in cycle t+1.
- Same-set handover: owner releases in cycle t and the waiter's grant rises in cycle t+2. There is one idle bubble; no same-edge handover.
- The grant stays high until release, with no timeout.

## Test plan
- Uncontended CPU access: cpuRequest=1, cpuAddress=0x100 at t0 -> cpuGrant=1 at t1. cpuRelease at t3 -> cpuGrant=0 at t4. snoopStreak stays 0.
- Different sets in parallel: cpuAddress=0x100 (index 0x10) and snoopyAddress=0x110 (index 0x11), both requested at t0 -> both grants high at t1, cpuBlocked=0 throughout.
- Same-set collision with different tags: cpuAddress=0x100 and snoopyAddress=0x500 (both index 0x10), simultaneous at t0 -> snoopyGrant=1 at t1, cpuBlocked=1, snoopStreak=1. snoopyRelease at t2 -> cpuGrant=1 at t4, snoopStreak=0.
- Starvation guard, MAX_SNOOP_STREAK=3: CPU holds request on index 0x10 while snoopy makes repeated request/release cycles on 0x500.
  - snoopStreak goes 1, 2, 3.
  - Fourth simultaneous contest -> cpuGrant=1, snoopyGrant stays 0, snoopStreak=0.
- Reset mid-hold: both grants high on different sets, reset pulsed for 1 cycle -> both grants 0 and snoopStreak=0 at the next edge. Requests still high after reset -> grants return one cycle after reset deasserts.
- Spurious release: cpuRelease=1 with cpuGrant=0 and cpuRequest=0 -> no state change, and no grant appears.
